// File: rtl/if_id_fetch_queue.sv
// Fetch-to-decode in-order bundle queue with valid/ready on both sides.
// Define IF_ID_BUBBLE_NOP_EN to present addi x0,x0,0 while empty.
module if_id_fetch_queue #(
  parameter int XLEN  = 32,
  parameter int ILEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ILEN-1:0]          in_instr,
  input  logic [XLEN-1:0]          in_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ILEN-1:0]          out_instr,
  output logic [XLEN-1:0]          out_pc,
  output logic [4:0]               out_rd,
  output logic [4:0]               out_rs1,
  output logic [4:0]               out_rs2,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
`ifdef IF_ID_BUBBLE_NOP_EN
  localparam logic [ILEN-1:0] BUBBLE = ILEN'(32'h0000_0013);
`else
  localparam logic [ILEN-1:0] BUBBLE = '0;
`endif

  logic [ILEN-1:0] instr_mem [DEPTH];
  logic [XLEN-1:0] pc_mem    [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop;

  assign in_ready  = (count_q != FULL);
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign count     = count_q;

  // Next pointer/occupancy state; flush overrides any handshake.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state; reset empties the queue without a clock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents survive flush, only occupancy is cleared.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      instr_mem[wr_ptr_q] <= in_instr;
      pc_mem[wr_ptr_q]    <= in_pc;
    end
  end

  // Head presentation with bubble value while empty.
  always_comb begin
    out_instr = BUBBLE;
    out_pc    = '0;
    if (out_valid) begin
      out_instr = instr_mem[rd_ptr_q];
      out_pc    = pc_mem[rd_ptr_q];
    end
    out_rd  = out_instr[11:7];
    out_rs1 = out_instr[19:15];
    out_rs2 = out_instr[24:20];
  end

endmodule

// File: tb/tb_if_id_fetch_queue.sv
// Randomised and directed bench for the fetch queue.
// Uses a queue-based reference model of the FIFO behaviour.
module tb_if_id_fetch_queue;

  localparam int DEPTH = 2;
`ifdef IF_ID_BUBBLE_NOP_EN
  localparam logic [31:0] BUB = 32'h0000_0013;
`else
  localparam logic [31:0] BUB = 32'h0000_0000;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic [1:0]  count;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;
  ent_t mq[$];

  if_id_fetch_queue #(.XLEN(32), .ILEN(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc),
    .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    logic [31:0] ei;
    logic [31:0] ep;
    ei = BUB;
    ep = '0;
    if (mq.size() != 0) begin
      ei = mq[0].instr;
      ep = mq[0].pc;
    end
    chk({tag, ".count"}, 64'(count), 64'(mq.size()));
    chk({tag, ".out_valid"}, 64'(out_valid), 64'(mq.size() != 0));
    chk({tag, ".in_ready"}, 64'(in_ready), 64'(mq.size() != DEPTH));
    chk({tag, ".out_instr"}, 64'(out_instr), 64'(ei));
    chk({tag, ".out_pc"}, 64'(out_pc), 64'(ep));
    chk({tag, ".out_rd"}, 64'(out_rd), 64'(ei[11:7]));
    chk({tag, ".out_rs1"}, 64'(out_rs1), 64'(ei[19:15]));
    chk({tag, ".out_rs2"}, 64'(out_rs2), 64'(ei[24:20]));
  endtask

  // One clock: check at negedge, drive, then advance the model at posedge.
  task automatic cyc(string tag, bit iv, logic [31:0] ins,
                     logic [31:0] pc, bit ordy, bit fl);
    bit do_push, do_pop;
    @(negedge clk);
    check_all(tag);
    in_valid  = iv;
    in_instr  = ins;
    in_pc     = pc;
    out_ready = ordy;
    flush     = fl;
    do_push = iv && (mq.size() < DEPTH);
    do_pop  = ordy && (mq.size() > 0);
    @(posedge clk);
    if (fl) begin
      mq.delete();
    end else begin
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back('{ins, pc});
    end
  endtask

  task automatic idle();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
  endtask

  initial begin
    logic [31:0] pc;
    // reset held with fetch presenting a bundle
    reset = 1'b0;
    in_valid = 1'b1;
    in_instr = 32'hDEAD_BEEF;
    in_pc = 32'h40;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.count", 64'(count), 64'd0);
    chk("rst.out_valid", 64'(out_valid), 64'd0);
    chk("rst.in_ready", 64'(in_ready), 64'd1);
    chk("rst.out_instr", 64'(out_instr), 64'(BUB));
    chk("rst.out_pc", 64'(out_pc), 64'd0);
    idle();
    reset = 1'b1;

    // first push, decoded fields
    cyc("push1", 1, 32'h00A3_0293, 32'h100, 0, 0);
    @(negedge clk);
    chk("dec.rd", 64'(out_rd), 64'd5);
    chk("dec.rs1", 64'(out_rs1), 64'd6);
    chk("dec.rs2", 64'(out_rs2), 64'd10);
    chk("dec.pc", 64'(out_pc), 64'h100);
    idle();
    cyc("drain1", 0, '0, '0, 1, 0);

    // fill / backpressure
    cyc("fill0", 1, 32'h0000_0001, 32'h0, 0, 0);
    cyc("fill1", 1, 32'h0000_0002, 32'h4, 0, 0);
    cyc("fill2", 1, 32'h0000_0003, 32'h8, 0, 0);
    cyc("full1", 0, '0, '0, 1, 0);
    cyc("full2", 0, '0, '0, 1, 0);
    cyc("empty_pop", 0, '0, '0, 1, 0);

    // streaming
    pc = 32'h1000;
    for (int i = 0; i < 10; i++) begin
      cyc("stream", 1, 32'h0001_0013 + 32'(i << 7), pc, 1, 0);
      pc += 32'd4;
    end
    cyc("stream_end", 0, '0, '0, 1, 0);

    // flush with concurrent push and pop
    cyc("fl_fill0", 1, 32'h1111_1111, 32'h200, 0, 0);
    cyc("fl_fill1", 1, 32'h2222_2222, 32'h204, 0, 0);
    cyc("flush", 1, 32'h3333_3333, 32'h208, 1, 1);
    cyc("post_fl", 1, 32'h4444_4444, 32'h300, 0, 0);
    cyc("post_fl2", 0, '0, '0, 1, 0);

    // async reset between edges
    cyc("ar_fill0", 1, 32'h5555_5555, 32'h400, 0, 0);
    cyc("ar_fill1", 1, 32'h6666_6666, 32'h404, 0, 0);
    @(negedge clk);
    check_all("ar_pre");
    idle();
    #1 reset = 1'b0;
    #1;
    mq.delete();
    chk("ar.count", 64'(count), 64'd0);
    chk("ar.out_valid", 64'(out_valid), 64'd0);
    check_all("ar_in");
    #1 reset = 1'b1;

    // randomised traffic
    for (int i = 0; i < 400; i++) begin
      cyc("rand", bit'($urandom_range(0, 3) != 0), $urandom(), $urandom(),
          bit'($urandom_range(0, 2) != 0),
          bit'($urandom_range(0, 19) == 0));
    end
    @(negedge clk);
    check_all("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
